// File: rtl/dnn_pkg.sv
// Shared constants and config types for the requantisation path.
// Narrowing targets signed INT8 activations from signed INT32 accumulators.
package dnn_pkg;

    localparam int ACC_W    = 32;
    localparam int MULT_W   = 16;
    localparam int OUT_W    = 8;
    localparam int SATCNT_W = 16;
    localparam int SHIFT_W  = 5;
    localparam int PROD_W   = ACC_W + MULT_W;

    localparam int QMIN = -128;
    localparam int QMAX = 127;

    typedef struct packed {
        logic signed [MULT_W-1:0]  mult;
        logic        [SHIFT_W-1:0] shift;
        logic signed [OUT_W-1:0]   zp;
        logic                      relu;
    } requant_cfg_t;

    // Identity transform: mult=1, no shift, no zero point, no ReLU.
    localparam requant_cfg_t CFG_IDENTITY = '{
        mult:  MULT_W'(1),
        shift: '0,
        zp:    '0,
        relu:  1'b0
    };

endpackage

// File: rtl/requant_sat.sv
// Combinational arithmetic for the requant pipeline.
// Two independent paths: the rounding shift used by stage 2, and the
// zero-point add plus INT8 clamp used by stage 3.
module requant_sat
    import dnn_pkg::*;
(
    input  logic signed [PROD_W-1:0]  prod,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [PROD_W-1:0]  rnd,
    input  logic signed [PROD_W-1:0]  r,
    input  logic signed [OUT_W-1:0]   zp,
    input  logic                      relu,
    output logic signed [OUT_W-1:0]   q,
    output logic                      sat
);

    localparam logic signed [PROD_W:0] V_MAX = (PROD_W+1)'(QMAX);
    localparam logic signed [PROD_W:0] V_MIN = (PROD_W+1)'(QMIN);

    logic signed [PROD_W:0] biased;
    logic signed [PROD_W:0] shifted;
    logic signed [PROD_W:0] v;

    // Round half up: add half an LSB of the result, then arithmetic shift.
    // One extra bit of headroom keeps the bias add from wrapping.
    always_comb begin
        biased = {prod[PROD_W-1], prod};
        if (shift != '0) begin
            biased = biased + ((PROD_W+1)'(1) << (shift - SHIFT_W'(1)));
        end
        shifted = biased >>> shift;
        rnd     = shifted[PROD_W-1:0];
    end

    // Add the zero point, then clamp; a ReLU floor is not a saturation event.
    always_comb begin
        v   = {r[PROD_W-1], r} + {{(PROD_W+1-OUT_W){zp[OUT_W-1]}}, zp};
        q   = v[OUT_W-1:0];
        sat = 1'b0;
        if (v > V_MAX) begin
            q   = OUT_W'(QMAX);
            sat = 1'b1;
        end else if (relu && (v < 0)) begin
            q   = '0;
        end else if (v < V_MIN) begin
            q   = OUT_W'(QMIN);
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/requant_unit.sv
// requant_unit: INT32 accumulator -> INT8 activation, 3-stage valid/ready pipe.
//   S1 multiply, S2 rounding shift, S3 zero point + clamp into out_data.
// The whole pipe moves together; a stalled output freezes every stage.
// Build option: define REQUANT_RELU_EN to add the cfg_relu port and the
// ReLU floor at 0 (floored values are not counted as saturation).
module requant_unit
    import dnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ACC_W-1:0]    acc_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    input  logic                cfg_load,
    output logic                cfg_ready,
    input  logic [MULT_W-1:0]   cfg_mult,
    input  logic [SHIFT_W-1:0]  cfg_shift,
    input  logic [OUT_W-1:0]    cfg_zp,
`ifdef REQUANT_RELU_EN
    input  logic                cfg_relu,
`endif
    output logic [SATCNT_W-1:0] sat_count,
    input  logic                sat_clear
);

    requant_cfg_t cfg_q;

    logic advance;
    logic accept;
    logic s1_valid;
    logic s2_valid;
    logic s3_valid;
    logic s3_sat;

    logic signed [PROD_W-1:0] s1_prod;
    logic signed [PROD_W-1:0] s2_r;
    logic signed [PROD_W-1:0] rnd;
    logic signed [OUT_W-1:0]  q;
    logic                     q_sat;
    logic        [OUT_W-1:0]  out_q;
    logic      [SATCNT_W-1:0] sat_q;

    assign advance   = !s3_valid || out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid && advance;
    // Config may only change while nothing is in flight, so every stage can
    // read cfg_q directly without carrying a per-item copy.
    assign cfg_ready = !(s1_valid || s2_valid || s3_valid) && !accept;

    assign out_valid = s3_valid;
    assign out_data  = out_q;
    assign sat_count = sat_q;

    requant_sat u_sat (
        .prod  (s1_prod),
        .shift (cfg_q.shift),
        .rnd   (rnd),
        .r     (s2_r),
        .zp    (cfg_q.zp),
        .relu  (cfg_q.relu),
        .q     (q),
        .sat   (q_sat)
    );

    // Config register; loads only when the pipe is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= CFG_IDENTITY;
        end else if (cfg_load && cfg_ready) begin
            cfg_q.mult  <= cfg_mult;
            cfg_q.shift <= cfg_shift;
            cfg_q.zp    <= cfg_zp;
`ifdef REQUANT_RELU_EN
            cfg_q.relu  <= cfg_relu;
`else
            cfg_q.relu  <= 1'b0;
`endif
        end
    end

    // Pipeline stages; all advance on the same condition to keep FIFO order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_prod  <= '0;
            s2_r     <= '0;
            out_q    <= '0;
            s3_sat   <= 1'b0;
        end else if (advance) begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            if (accept) begin
                s1_prod <= $signed(acc_in) * $signed(cfg_q.mult);
            end
            if (s1_valid) begin
                s2_r <= rnd;
            end
            if (s2_valid) begin
                out_q  <= q;
                s3_sat <= q_sat;
            end
        end
    end

    // Saturation event counter; sticks at all-ones, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else if (sat_clear) begin
            sat_q <= '0;
        end else if (s3_valid && out_ready && s3_sat && !(&sat_q)) begin
            sat_q <= sat_q + SATCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_requant_unit.sv
// Bench for requant_unit: directed vectors with literal expectations plus a
// reference model (plain integer arithmetic) checked on every output transfer.
module tb_requant_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] acc_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        cfg_load;
    logic        cfg_ready;
    logic [15:0] cfg_mult;
    logic [4:0]  cfg_shift;
    logic [7:0]  cfg_zp;
    logic        cfg_relu;
    logic [15:0] sat_count;
    logic        sat_clear;

    always #5 clk = ~clk;

    requant_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_in    (acc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_load  (cfg_load),
        .cfg_ready (cfg_ready),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
`ifdef REQUANT_RELU_EN
        .cfg_relu  (cfg_relu),
`endif
        .sat_count (sat_count),
        .sat_clear (sat_clear)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_xfer = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_mult  = 1;
    int     m_shift = 0;
    longint m_zp    = 0;
    bit     m_relu  = 0;
    int     m_sat   = 0;
    int     exp_q[$];
    bit     exp_s[$];
    bit     hold_pend = 0;
    int     hold_data = 0;

    function automatic longint floor_div(input longint a, input longint d);
        longint qq;
        qq = a / d;
        if ((a % d != 0) && (a < 0)) qq = qq - 1;
        return qq;
    endfunction

    function automatic void model(input longint acc, output int q, output bit s);
        longint p, r, v, half, den;
        p = acc * m_mult;
        if (m_shift == 0) begin
            r = p;
        end else begin
            den  = longint'(1) << m_shift;
            half = den / 2;
            r    = floor_div(p + half, den);
        end
        v = r + m_zp;
        s = 1'b0;
        if (v > 127) begin
            q = 127; s = 1'b1;
        end else if (m_relu && v < 0) begin
            q = 0;
        end else if (v < -128) begin
            q = -128; s = 1'b1;
        end else begin
            q = int'(v);
        end
    endfunction

    // Compare process: handshake rules, output order/values, hold stability, sat counter.
    always @(negedge clk) begin
        int  e;
        bit  s;
        bit  xfer_sat;
        bit  exp_in_ready;
        bit  exp_cfg_ready;
        if (!rst_n) begin
            exp_q.delete();
            exp_s.delete();
            m_sat = 0; m_mult = 1; m_shift = 0; m_zp = 0; m_relu = 0;
            hold_pend = 0;
        end else begin
            xfer_sat      = 1'b0;
            exp_in_ready  = !out_valid || out_ready;
            exp_cfg_ready = (exp_q.size() == 0) && !(in_valid && exp_in_ready);
            chk("in_ready", in_ready, exp_in_ready);
            chk("cfg_ready", cfg_ready, exp_cfg_ready);
            chk("sat_count", sat_count, m_sat);
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", $signed(out_data), hold_data);
            end
            hold_pend = out_valid && !out_ready;
            hold_data = $signed(out_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    s = exp_s.pop_front();
                    chk("out_data", $signed(out_data), e);
                    xfer_sat = s;
                    n_xfer++;
                end
            end
            if (sat_clear) m_sat = 0;
            else if (xfer_sat && m_sat != 65535) m_sat++;
            if (in_valid && exp_in_ready) begin
                model($signed(acc_in), e, s);
                exp_q.push_back(e);
                exp_s.push_back(s);
            end
            if (cfg_load && exp_cfg_ready) begin
                m_mult  = $signed(cfg_mult);
                m_shift = int'(cfg_shift);
                m_zp    = $signed(cfg_zp);
`ifdef REQUANT_RELU_EN
                m_relu  = cfg_relu;
`else
                m_relu  = 1'b0;
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_cfg(input int mult, input int shift, input int zp, input bit relu);
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_mult = 16'(mult); cfg_shift = 5'(shift);
        cfg_zp = 8'(zp); cfg_relu = relu;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    // Sends one value, waits for its result; lat counts cycles from the accept cycle.
    task automatic send_one(input longint acc, output int data, output int lat);
        bit ok;
        data = 0; lat = -1; ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; acc_in = 32'(acc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", ok, 1);
            return;
        end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                data = $signed(out_data);
                lat  = i + 1;
                break;
            end
        end
        if (lat < 0) chk("out_timeout", out_valid, 1);
        @(posedge clk); #1;
    endtask

    int d, lat;
    int vals[6] = '{11, -22, 33, -44, 55, -66};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, x0, t;
        rst_n = 1'b0; in_valid = 1'b0; acc_in = '0; out_ready = 1'b1;
        cfg_load = 1'b0; cfg_mult = '0; cfg_shift = '0; cfg_zp = '0; cfg_relu = 1'b0;
        sat_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat_count", sat_count, 0);

        // 1: identity, latency 3
        send_one(100, d, lat);
        chk("t1_data", d, 100);
        chk("t1_latency", lat, 3);

        // 2: round half up with shift=1
        load_cfg(1, 1, 0, 0);
        send_one(3, d, lat);  chk("t2_p3", d, 2);
        send_one(-3, d, lat); chk("t2_m3", d, -1);
        send_one(2, d, lat);  chk("t2_p2", d, 1);

        // 3: saturation and clear
        load_cfg(1, 0, 0, 0);
        send_one(1000, d, lat);  chk("t3_hi", d, 127);
        send_one(-1000, d, lat); chk("t3_lo", d, -128);
        chk("t3_satcnt", sat_count, 2);
        @(posedge clk); #1 sat_clear = 1'b1;
        @(posedge clk); #1 sat_clear = 1'b0;
        chk("t3_satclr", sat_count, 0);

        // 4: zero point with negative rounding
        load_cfg(3, 2, 10, 0);
        send_one(-5, d, lat); chk("t4_zp", d, 6);

        // 6a: cfg_load while busy is dropped
        @(posedge clk); #1 in_valid = 1'b1; acc_in = 32'd8;
        @(posedge clk); #1 in_valid = 1'b0;
        cfg_load = 1'b1; cfg_mult = 16'd5; cfg_shift = '0; cfg_zp = '0;
        @(negedge clk);
        chk("t6_busy_cfg_ready", cfg_ready, 0);
        @(posedge clk); #1 cfg_load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send_one(-5, d, lat); chk("t6_old_cfg", d, 6);

        // 6b: reset mid-stream discards in-flight data and restores identity
        @(posedge clk); #1 in_valid = 1'b1; acc_in = 32'd40;
        @(posedge clk); #1 acc_in = 32'd41;
        @(posedge clk); #1 in_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_rst_no_out", out_valid, 0);
        end
        send_one(100, d, lat); chk("t6_identity", d, 100);

        // 5: stream 6 under a 5-cycle output stall
        x0 = n_xfer; idx = 0;
        for (t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            out_ready = (t >= 5);
            in_valid  = (idx < 6);
            acc_in    = (idx < 6) ? 32'(vals[idx]) : '0;
            @(negedge clk);
            if (t == 4) begin
                chk("t5_accepts", idx + int'(in_valid && in_ready), 3);
                chk("t5_in_ready_low", in_ready, 0);
            end
            if (in_valid && in_ready) idx++;
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        chk("t5_outputs", n_xfer - x0, 6);
        chk("t5_pending", exp_q.size(), 0);

        // 6c: ReLU floor
        load_cfg(1, 0, 0, 1);
        send_one(-50, d, lat);
`ifdef REQUANT_RELU_EN
        chk("t6_relu", d, 0);
`else
        chk("t6_relu", d, -50);
`endif
        send_one(-200, d, lat);
`ifdef REQUANT_RELU_EN
        chk("t6_relu_deep", d, 0);
        chk("t6_relu_nosat", sat_count, 0);
`else
        chk("t6_relu_deep", d, -128);
        chk("t6_relu_nosat", sat_count, 1);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
